// File: rtl/ctrl_host_sync.sv
// ctrl_host_sync
// Host-side initiator for the byte-synchronous Wishbone tunnelling protocol.
// Takes one register request at a time (read or write, 4-bit address, 8-bit
// data), serialises it into command / data / poll / fetch bytes on a
// full-duplex byte link, watches the reply stream for the 0x01 acknowledge,
// and returns read data or completion status to the requester.
//
// Parameters
//   MaxPoll      number of 0x00 poll replies tolerated before timing out (>=1)
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   req_valid_i  request present
//   req_ready_o  request accepted this cycle when high (Idle only)
//   req_we_i     1 = write, 0 = read
//   req_adr_i    register address
//   req_dat_i    write data (ignored for reads)
//   rsp_valid_o  one-cycle pulse when a transaction completes
//   rsp_dat_o    read data, or offending byte on a bad reply; held
//   rsp_err_o    1 = timeout or bad reply; held with rsp_dat_o
//   tx_data_o    byte offered to the link
//   tx_valid_o   byte slot requested
//   tx_ready_i   link accepts the offered byte this cycle
//   rx_data_i    reply byte for the last accepted slot
//   rx_valid_i   reply strobe, one per accepted tx byte

module ctrl_host_sync #(
    parameter int MaxPoll = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_we_i,
    input  logic [3:0] req_adr_i,
    input  logic [7:0] req_dat_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_dat_o,
    output logic       rsp_err_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i
);

    localparam int CntW = $clog2(MaxPoll + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxPoll);

    typedef enum logic [3:0] {
        StIdle,
        StSendCmd,
        StWaitCmd,
        StSendData,
        StWaitData,
        StSendPoll,
        StWaitPoll,
        StSendFetch,
        StWaitFetch
    } state_t;

    state_t            r_state;
    logic              r_we;
    logic [7:0]        r_dat;
    logic [CntW-1:0]   r_pollCnt;
    logic [7:0]        r_txData;
    logic              r_txValid;
    logic              r_rspValid;
    logic [7:0]        r_rspDat;
    logic              r_rspErr;
    logic [CntW-1:0]   w_pollInc;

    // Poll count after one more zero reply. It holds at MaxPoll rather than
    // wrapping, although reaching MaxPoll already ends the transaction.
    assign w_pollInc = (r_pollCnt == MaxCnt) ? MaxCnt : r_pollCnt + CntW'(1);

    // The ready flag is a pure decode of the state register so a new request
    // can be taken in the same cycle the previous response pulses.
    assign req_ready_o = (r_state == StIdle);
    assign tx_data_o   = r_txData;
    assign tx_valid_o  = r_txValid;
    assign rsp_valid_o = r_rspValid;
    assign rsp_dat_o   = r_rspDat;
    assign rsp_err_o   = r_rspErr;

    // Main sequencer. Every byte goes through a Send state (offer the byte
    // until the link takes it) and a Wait state (hold off until its reply
    // arrives). The byte for the next Send is loaded into r_txData on the way
    // in, so tx_data_o is stable for the whole Send. The address is not kept
    // separately: it only ever appears inside the command byte, which is
    // built straight from the request inputs on acceptance. Replies to the
    // command and data slots carry no information and are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= StIdle;
            r_we       <= 1'b0;
            r_dat      <= 8'h00;
            r_pollCnt  <= '0;
            r_txData   <= 8'h00;
            r_txValid  <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspDat   <= 8'h00;
            r_rspErr   <= 1'b0;
        end else begin
            r_rspValid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (req_valid_i) begin
                        r_we      <= req_we_i;
                        r_dat     <= req_dat_i;
                        r_pollCnt <= '0;
                        r_txData  <= {req_we_i, 3'b000, req_adr_i};
                        r_txValid <= 1'b1;
                        r_state   <= StSendCmd;
                    end
                end

                StSendCmd: begin
                    if (tx_ready_i) begin
                        r_txValid <= 1'b0;
                        r_state   <= StWaitCmd;
                    end
                end

                StWaitCmd: begin
                    if (rx_valid_i) begin
                        r_txValid <= 1'b1;
                        if (r_we) begin
                            r_txData <= r_dat;
                            r_state  <= StSendData;
                        end else begin
                            r_txData <= 8'h00;
                            r_state  <= StSendPoll;
                        end
                    end
                end

                StSendData: begin
                    if (tx_ready_i) begin
                        r_txValid <= 1'b0;
                        r_state   <= StWaitData;
                    end
                end

                StWaitData: begin
                    if (rx_valid_i) begin
                        r_txData  <= 8'h00;
                        r_txValid <= 1'b1;
                        r_state   <= StSendPoll;
                    end
                end

                StSendPoll: begin
                    if (tx_ready_i) begin
                        r_txValid <= 1'b0;
                        r_state   <= StWaitPoll;
                    end
                end

                // 0x01 is the acknowledge, 0x00 means "not yet", anything
                // else is a protocol error reported with the offending byte.
                StWaitPoll: begin
                    if (rx_valid_i) begin
                        if (rx_data_i == 8'h01) begin
                            if (r_we) begin
                                r_rspValid <= 1'b1;
                                r_rspDat   <= 8'h00;
                                r_rspErr   <= 1'b0;
                                r_state    <= StIdle;
                            end else begin
                                r_txData  <= 8'h00;
                                r_txValid <= 1'b1;
                                r_state   <= StSendFetch;
                            end
                        end else if (rx_data_i == 8'h00) begin
                            r_pollCnt <= w_pollInc;
                            if (w_pollInc == MaxCnt) begin
                                r_rspValid <= 1'b1;
                                r_rspDat   <= 8'h00;
                                r_rspErr   <= 1'b1;
                                r_state    <= StIdle;
                            end else begin
                                r_txData  <= 8'h00;
                                r_txValid <= 1'b1;
                                r_state   <= StSendPoll;
                            end
                        end else begin
                            r_rspValid <= 1'b1;
                            r_rspDat   <= rx_data_i;
                            r_rspErr   <= 1'b1;
                            r_state    <= StIdle;
                        end
                    end
                end

                StSendFetch: begin
                    if (tx_ready_i) begin
                        r_txValid <= 1'b0;
                        r_state   <= StWaitFetch;
                    end
                end

                StWaitFetch: begin
                    if (rx_valid_i) begin
                        r_rspValid <= 1'b1;
                        r_rspDat   <= rx_data_i;
                        r_rspErr   <= 1'b0;
                        r_state    <= StIdle;
                    end
                end

                default: begin
                    r_txValid <= 1'b0;
                    r_state   <= StIdle;
                end
            endcase
        end
    end

endmodule
